// File: rtl/reservation_station_pkg.sv
// Shared types and default sizes for the reservation station slice.
// Optional build macro: RS_AGE_SELECT_EN (oldest-first issue).
package reservation_station_pkg;

    localparam int RS_SIZE      = 8;
    localparam int ROB_IDX_SIZE = 5;
    localparam int GPR_SIZE     = 64;
    localparam int ALU_OP_SIZE  = 6;

    typedef logic [ALU_OP_SIZE-1:0] alu_op_t;

    typedef struct packed {
        logic                    valid;
        logic [ROB_IDX_SIZE-1:0] rob_index;
        logic [GPR_SIZE-1:0]     value;
    } rs_op;

    typedef struct packed {
        logic                    entry_valid;
        rs_op                    op1;
        rs_op                    op2;
        logic [ROB_IDX_SIZE-1:0] dst_rob;
    } rs_entry;

endpackage

// File: rtl/reservation_station_if.sv
// Dispatch / CDB / issue bundle of the reservation station.
// Operands are packed {valid, rob_index, value}, value in the LSBs.
interface reservation_station_if
    import reservation_station_pkg::*;
#(
    parameter int RS_DEPTH  = RS_SIZE,
    parameter int DATA_W    = GPR_SIZE,
    parameter int ROB_IDX_W = ROB_IDX_SIZE,
    parameter int CDB_PORTS = 2,
    parameter int OP_W      = ALU_OP_SIZE
);
    localparam int OPND_W = 1 + ROB_IDX_W + DATA_W;
    localparam int CNT_W  = $clog2(RS_DEPTH) + 1;

    logic                           in_valid;
    logic                           in_ready;
    logic [OPND_W-1:0]              in_op1;
    logic [OPND_W-1:0]              in_op2;
    logic [ROB_IDX_W-1:0]           in_dst_rob;
    logic [OP_W-1:0]                in_op;
    logic [CDB_PORTS-1:0]           cdb_valid;
    logic [CDB_PORTS*ROB_IDX_W-1:0] cdb_rob;
    logic [CDB_PORTS*DATA_W-1:0]    cdb_value;
    logic                           iss_valid;
    logic                           iss_ready;
    logic [DATA_W-1:0]              iss_op1_val;
    logic [DATA_W-1:0]              iss_op2_val;
    logic [ROB_IDX_W-1:0]           iss_dst_rob;
    logic [OP_W-1:0]                iss_op;
    logic [CNT_W-1:0]               occupancy;

    modport master (
        output in_valid, in_op1, in_op2, in_dst_rob, in_op,
        output cdb_valid, cdb_rob, cdb_value, iss_ready,
        input  in_ready, iss_valid, iss_op1_val, iss_op2_val,
        input  iss_dst_rob, iss_op, occupancy
    );

    modport slave (
        input  in_valid, in_op1, in_op2, in_dst_rob, in_op,
        input  cdb_valid, cdb_rob, cdb_value, iss_ready,
        output in_ready, iss_valid, iss_op1_val, iss_op2_val,
        output iss_dst_rob, iss_op, occupancy
    );

endinterface

// File: rtl/reservation_station_rs_select.sv
// Issue arbiter: one-hot grant over the ready vector.
// RS_AGE_SELECT_EN: oldest ready wins, else lowest index wins.
module rs_select #(
    parameter int N = 8
) (
    input  logic [N-1:0]   req,
`ifdef RS_AGE_SELECT_EN
    input  logic [N*N-1:0] age,
`endif
    output logic [N-1:0]   grant,
    output logic           any
);

    assign any = |req;

`ifdef RS_AGE_SELECT_EN
    // age[i*N+j] set means entry i is older than entry j
    always_comb begin
        grant = req;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (j != i && req[j] && !age[i*N+j]) begin
                    grant[i] = 1'b0;
                end
            end
        end
    end
`else
    assign grant = req & (~req + N'(1));
`endif

endmodule

// File: rtl/reservation_station.sv
// Tomasulo reservation station with CDB wakeup and single issue.
// Optional build macro: RS_AGE_SELECT_EN (oldest-first issue).
module reservation_station
    import reservation_station_pkg::*;
#(
    parameter int RS_DEPTH  = RS_SIZE,
    parameter int DATA_W    = GPR_SIZE,
    parameter int ROB_IDX_W = ROB_IDX_SIZE,
    parameter int CDB_PORTS = 2,
    parameter int OP_W      = ALU_OP_SIZE
) (
    input logic clk,
    input logic rst,
    input logic flush,
    reservation_station_if.slave bus
);

    localparam int CNT_W = $clog2(RS_DEPTH) + 1;

    logic [RS_DEPTH-1:0]  ent_v, op1_v, op2_v;
    logic [ROB_IDX_W-1:0] op1_tag [RS_DEPTH];
    logic [ROB_IDX_W-1:0] op2_tag [RS_DEPTH];
    logic [DATA_W-1:0]    op1_val [RS_DEPTH];
    logic [DATA_W-1:0]    op2_val [RS_DEPTH];
    logic [ROB_IDX_W-1:0] dst_q   [RS_DEPTH];
    logic [OP_W-1:0]      op_q    [RS_DEPTH];

    logic [DATA_W:0]      w1 [RS_DEPTH];
    logic [DATA_W:0]      w2 [RS_DEPTH];
    logic [DATA_W:0]      win1, win2;
    logic [RS_DEPTH-1:0]  rdy, grant, free, free_oh;
    logic [CNT_W-1:0]     occ;
    logic                 any_rdy, ins, iss;

    logic                 in1_v, in2_v;
    logic [ROB_IDX_W-1:0] in1_tag, in2_tag;
    logic [DATA_W-1:0]    in1_val, in2_val;

    assign in1_v   = bus.in_op1[DATA_W+ROB_IDX_W];
    assign in1_tag = bus.in_op1[DATA_W +: ROB_IDX_W];
    assign in1_val = bus.in_op1[DATA_W-1:0];
    assign in2_v   = bus.in_op2[DATA_W+ROB_IDX_W];
    assign in2_tag = bus.in_op2[DATA_W +: ROB_IDX_W];
    assign in2_val = bus.in_op2[DATA_W-1:0];

    // Returns {hit, value}; scanning downward lets the lowest port win
    function automatic logic [DATA_W:0] snoop(
        input logic [ROB_IDX_W-1:0]           tag,
        input logic [CDB_PORTS-1:0]           cv,
        input logic [CDB_PORTS*ROB_IDX_W-1:0] cr,
        input logic [CDB_PORTS*DATA_W-1:0]    cd
    );
        logic [DATA_W:0] r;
        r = '0;
        for (int p = CDB_PORTS - 1; p >= 0; p--) begin
            if (cv[p] && cr[p*ROB_IDX_W +: ROB_IDX_W] == tag) begin
                r = {1'b1, cd[p*DATA_W +: DATA_W]};
            end
        end
        return r;
    endfunction

    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            w1[i] = snoop(op1_tag[i], bus.cdb_valid, bus.cdb_rob, bus.cdb_value);
            w2[i] = snoop(op2_tag[i], bus.cdb_valid, bus.cdb_rob, bus.cdb_value);
        end
        win1 = snoop(in1_tag, bus.cdb_valid, bus.cdb_rob, bus.cdb_value);
        win2 = snoop(in2_tag, bus.cdb_valid, bus.cdb_rob, bus.cdb_value);
    end

    always_comb begin
        occ = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            occ = occ + CNT_W'(ent_v[i]);
        end
    end

    assign rdy     = ent_v & op1_v & op2_v;
    assign free    = ~ent_v;
    assign free_oh = free & (~free + RS_DEPTH'(1));

    assign bus.occupancy = occ;
    assign bus.in_ready  = (occ != CNT_W'(RS_DEPTH));
    assign bus.iss_valid = any_rdy;
    assign ins = bus.in_valid & bus.in_ready;
    assign iss = any_rdy & bus.iss_ready;

`ifdef RS_AGE_SELECT_EN
    logic [RS_DEPTH-1:0]          age [RS_DEPTH];
    logic [RS_DEPTH*RS_DEPTH-1:0] age_flat;

    // New entry: every other row marks it younger, its own row is cleared
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RS_DEPTH; i++) age[i] <= '0;
        end else if (ins && !flush) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                for (int j = 0; j < RS_DEPTH; j++) begin
                    if (free_oh[i]) age[i][j] <= 1'b0;
                    else if (free_oh[j]) age[i][j] <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            age_flat[i*RS_DEPTH +: RS_DEPTH] = age[i];
        end
    end

    rs_select #(.N(RS_DEPTH)) u_sel (
        .req(rdy), .age(age_flat), .grant(grant), .any(any_rdy)
    );
`else
    rs_select #(.N(RS_DEPTH)) u_sel (
        .req(rdy), .grant(grant), .any(any_rdy)
    );
`endif

    always_comb begin
        bus.iss_op1_val = '0;
        bus.iss_op2_val = '0;
        bus.iss_dst_rob = '0;
        bus.iss_op      = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (grant[i]) begin
                bus.iss_op1_val = bus.iss_op1_val | op1_val[i];
                bus.iss_op2_val = bus.iss_op2_val | op2_val[i];
                bus.iss_dst_rob = bus.iss_dst_rob | dst_q[i];
                bus.iss_op      = bus.iss_op | op_q[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_v <= '0;
            op1_v <= '0;
            op2_v <= '0;
            for (int i = 0; i < RS_DEPTH; i++) begin
                op1_tag[i] <= '0;
                op2_tag[i] <= '0;
                op1_val[i] <= '0;
                op2_val[i] <= '0;
                dst_q[i]   <= '0;
                op_q[i]    <= '0;
            end
        end else if (flush) begin
            ent_v <= '0;
            op1_v <= '0;
            op2_v <= '0;
        end else begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (ins && free_oh[i]) begin
                    ent_v[i]   <= 1'b1;
                    op1_v[i]   <= in1_v | win1[DATA_W];
                    op2_v[i]   <= in2_v | win2[DATA_W];
                    op1_tag[i] <= in1_tag;
                    op2_tag[i] <= in2_tag;
                    op1_val[i] <= in1_v ? in1_val : win1[DATA_W-1:0];
                    op2_val[i] <= in2_v ? in2_val : win2[DATA_W-1:0];
                    dst_q[i]   <= bus.in_dst_rob;
                    op_q[i]    <= bus.in_op;
                end else begin
                    if (iss && grant[i]) ent_v[i] <= 1'b0;
                    if (ent_v[i] && !op1_v[i] && w1[i][DATA_W]) begin
                        op1_v[i]   <= 1'b1;
                        op1_val[i] <= w1[i][DATA_W-1:0];
                    end
                    if (ent_v[i] && !op2_v[i] && w2[i][DATA_W]) begin
                        op2_v[i]   <= 1'b1;
                        op2_val[i] <= w2[i][DATA_W-1:0];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station, default parameters.
// Expected issue order follows RS_AGE_SELECT_EN when defined.
module tb_reservation_station;
    import reservation_station_pkg::*;

`ifdef RS_AGE_SELECT_EN
    localparam bit AGE = 1'b1;
`else
    localparam bit AGE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic flush;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    reservation_station_if bus ();

    reservation_station dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .bus(bus.slave)
    );

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic rs_op opnd(input logic v,
                                  input logic [4:0] t,
                                  input logic [63:0] d);
        rs_op o;
        o.valid     = v;
        o.rob_index = t;
        o.value     = d;
        return o;
    endfunction

    task automatic set_in(input rs_op a, input rs_op b,
                          input logic [4:0] dst, input logic [5:0] op);
        bus.in_valid   = 1'b1;
        bus.in_op1     = a;
        bus.in_op2     = b;
        bus.in_dst_rob = dst;
        bus.in_op      = op;
    endtask

    task automatic push(input rs_op a, input rs_op b,
                        input logic [4:0] dst, input logic [5:0] op);
        set_in(a, b, dst, op);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic cdb_clear();
        bus.cdb_valid = '0;
        bus.cdb_rob   = '0;
        bus.cdb_value = '0;
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_op1 = '0;
        bus.in_op2 = '0;
        bus.in_dst_rob = '0;
        bus.in_op = '0;
        bus.iss_ready = 1'b0;
        cdb_clear();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_in_ready", 64'(bus.in_ready), 1);
        check("rst_iss_valid", 64'(bus.iss_valid), 0);
        check("rst_occ", 64'(bus.occupancy), 0);
        check("rst_op1", bus.iss_op1_val, 0);
        check("rst_dst", 64'(bus.iss_dst_rob), 0);

        // Both operands ready at insert
        push(opnd(1, 0, 5), opnd(1, 0, 7), 5'd3, 6'd1);
        check("t1_valid", 64'(bus.iss_valid), 1);
        check("t1_op1", bus.iss_op1_val, 5);
        check("t1_op2", bus.iss_op2_val, 7);
        check("t1_dst", 64'(bus.iss_dst_rob), 3);
        check("t1_op", 64'(bus.iss_op), 1);
        check("t1_occ", 64'(bus.occupancy), 1);
        bus.iss_ready = 1'b1;
        tick();
        bus.iss_ready = 1'b0;
        check("t1_occ_after", 64'(bus.occupancy), 0);
        check("t1_valid_after", 64'(bus.iss_valid), 0);

        // Wakeup from CDB port 1 two cycles after insert
        push(opnd(0, 9, 0), opnd(1, 0, 2), 5'd5, 6'd2);
        check("t2_wait0", 64'(bus.iss_valid), 0);
        check("t2_occ", 64'(bus.occupancy), 1);
        tick();
        check("t2_wait1", 64'(bus.iss_valid), 0);
        bus.cdb_valid = 2'b11;
        bus.cdb_rob   = {5'd9, 5'd7};
        bus.cdb_value = {64'h42, 64'h77};
        check("t2_no_same_cycle", 64'(bus.iss_valid), 0);
        tick();
        cdb_clear();
        check("t2_valid", 64'(bus.iss_valid), 1);
        check("t2_op1", bus.iss_op1_val, 64'h42);
        check("t2_op2", bus.iss_op2_val, 2);
        check("t2_dst", 64'(bus.iss_dst_rob), 5);
        bus.iss_ready = 1'b1;
        tick();
        bus.iss_ready = 1'b0;
        check("t2_occ_after", 64'(bus.occupancy), 0);

        // Capture during insert; both ports match, port 0 wins
        set_in(opnd(0, 4, 0), opnd(1, 0, 3), 5'd6, 6'd3);
        bus.cdb_valid = 2'b11;
        bus.cdb_rob   = {5'd4, 5'd4};
        bus.cdb_value = {64'd99, 64'd11};
        tick();
        bus.in_valid = 1'b0;
        cdb_clear();
        check("t3_valid", 64'(bus.iss_valid), 1);
        check("t3_op1", bus.iss_op1_val, 11);
        check("t3_op2", bus.iss_op2_val, 3);
        bus.iss_ready = 1'b1;
        tick();
        bus.iss_ready = 1'b0;
        check("t3_occ_after", 64'(bus.occupancy), 0);

        // Fill, overflow attempt, then drain
        for (int i = 0; i < 8; i++) begin
            push(opnd(1, 0, 64'(100 + i)), opnd(1, 0, 0), 5'(i), 6'd0);
        end
        check("t4_in_ready_full", 64'(bus.in_ready), 0);
        check("t4_occ_full", 64'(bus.occupancy), 8);
        push(opnd(1, 0, 1), opnd(1, 0, 1), 5'd20, 6'd0);
        check("t4_occ_ignored", 64'(bus.occupancy), 8);
        check("t4_head_val", bus.iss_op1_val, 100);
        check("t4_head_dst", 64'(bus.iss_dst_rob), 0);
        bus.iss_ready = 1'b1;
        tick();
        bus.iss_ready = 1'b0;
        check("t4_in_ready", 64'(bus.in_ready), 1);
        check("t4_occ_7", 64'(bus.occupancy), 7);
        bus.iss_ready = 1'b1;
        for (int k = 1; k < 8; k++) begin
            check($sformatf("t4_drain%0d", k), 64'(bus.iss_dst_rob), 64'(k));
            tick();
        end
        bus.iss_ready = 1'b0;
        check("t4_occ_empty", 64'(bus.occupancy), 0);
        check("t4_valid_empty", 64'(bus.iss_valid), 0);

        // Insert and issue in the same cycle
        push(opnd(1, 0, 1), opnd(1, 0, 1), 5'd10, 6'd0);
        set_in(opnd(1, 0, 2), opnd(1, 0, 2), 5'd11, 6'd0);
        bus.iss_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.iss_ready = 1'b0;
        check("t5_occ_same", 64'(bus.occupancy), 1);
        check("t5_dst", 64'(bus.iss_dst_rob), 11);
        bus.iss_ready = 1'b1;
        tick();
        bus.iss_ready = 1'b0;

        // Older A in slot 1, younger B in slot 0
        push(opnd(1, 0, 1), opnd(1, 0, 1), 5'd12, 6'd0);
        push(opnd(0, 2, 0), opnd(1, 0, 4), 5'd13, 6'd0);
        check("t6_f0_dst", 64'(bus.iss_dst_rob), 12);
        bus.iss_ready = 1'b1;
        tick();
        bus.iss_ready = 1'b0;
        push(opnd(1, 0, 6), opnd(1, 0, 7), 5'd14, 6'd0);
        bus.cdb_valid = 2'b01;
        bus.cdb_rob   = {5'd0, 5'd2};
        bus.cdb_value = {64'd0, 64'h22};
        tick();
        cdb_clear();
        check("t6_occ", 64'(bus.occupancy), 2);
        check("t6_first_dst", 64'(bus.iss_dst_rob), AGE ? 13 : 14);
        check("t6_first_op1", bus.iss_op1_val, AGE ? 64'h22 : 64'd6);
        bus.iss_ready = 1'b1;
        tick();
        check("t6_second_dst", 64'(bus.iss_dst_rob), AGE ? 14 : 13);
        tick();
        bus.iss_ready = 1'b0;
        check("t6_occ_after", 64'(bus.occupancy), 0);

        // Flush with five waiting entries and a concurrent insert
        for (int i = 0; i < 5; i++) begin
            push(opnd(0, 25, 0), opnd(1, 0, 0), 5'(i), 6'd0);
        end
        check("t7_occ5", 64'(bus.occupancy), 5);
        set_in(opnd(1, 0, 1), opnd(1, 0, 1), 5'd30, 6'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        check("t7_occ", 64'(bus.occupancy), 0);
        check("t7_valid", 64'(bus.iss_valid), 0);
        check("t7_in_ready", 64'(bus.in_ready), 1);
        tick();
        check("t7_dropped", 64'(bus.iss_valid), 0);

        // Asynchronous reset while an entry is ready
        push(opnd(1, 0, 8), opnd(1, 0, 9), 5'd7, 6'd0);
        check("t8_pre_valid", 64'(bus.iss_valid), 1);
        #2 rst = 1'b1;
        #1;
        check("t8_rst_valid", 64'(bus.iss_valid), 0);
        check("t8_rst_occ", 64'(bus.occupancy), 0);
        check("t8_rst_op1", bus.iss_op1_val, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reservation_station.md
# reservation_station

Parametrised Tomasulo reservation station for the out-of-order core. Holds up to `RS_DEPTH` dispatched micro-ops, captures missing source operands from `CDB_PORTS` common-data-bus broadcasts by ROB tag, and issues one ready entry per cycle to its functional unit through a valid/ready handshake. It sits between `dispatch` (insert side) and the ALU or LS unit (issue side), and supports a full pipeline flush.

## Interface
Parameters:
- `RS_DEPTH`, 8: number of entries; power of two, ≥2.
- `DATA_W`, 64: operand width.
- `ROB_IDX_W`, 5: ROB tag width.
- `CDB_PORTS`, 2: number of broadcast buses, ≥1.
- `OP_W`, 6: width of the opaque op field carried through (`alu_op_t`).

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: async active-high reset.
- `flush`  in  1: synchronous clear of all entries.
- `in_valid`  in  1: insert request.
- `in_ready`  out  1: a free entry exists.
- `in_op1`, `in_op2`  in  `rs_op`: {valid, rob_index, value}.
- `in_dst_rob`  in  `ROB_IDX_W`: destination tag.
- `in_op`  in  `OP_W`: operation code.
- `cdb_valid`  in  `CDB_PORTS`: broadcast valid per port.
- `cdb_rob`  in  `CDB_PORTS*ROB_IDX_W`: tag per port, port 0 in LSBs.
- `cdb_value`  in  `CDB_PORTS*DATA_W`: value per port.
- `iss_valid`  out  1: an entry is ready.
- `iss_ready`  in  1: FU accepts.
- `iss_op1_val`, `iss_op2_val`  out  `DATA_W`: operand values.
- `iss_dst_rob`  out  `ROB_IDX_W`.
- `iss_op`  out  `OP_W`.
- `occupancy`  out  `$clog2(RS_DEPTH)+1`: valid entry count.

## Operation
- Entry: `rs_entry` plus op field. `ready = entry_valid & op1.valid & op2.valid`, registered.
- Insert, `in_valid & in_ready`: write the lowest-index free entry.
- Insert with same-cycle CDB: an incoming operand with `valid=0` whose tag matches a valid CDB port is stored as captured. This is mandatory.
- Wakeup: on every edge, each valid entry's invalid operand whose `rob_index` matches a valid `cdb_rob[p]` latches `cdb_value[p]` and sets `valid`. If several ports match, the lowest port wins.
- Select: among ready entries, pick one (policy set under Configuration). `iss_valid = |ready`.
- Payload is combinational from the selected entry and is forced to 0 when `iss_valid=0`.
- Issue, `iss_valid & iss_ready`: the selected entry is cleared at the edge. `iss_ready` does not feed back combinationally into the select logic.
- `in_ready = (occupancy != RS_DEPTH)`. It does not count a same-cycle issue, so it is conservative.
- Simultaneous insert and issue is allowed. `occupancy` is unchanged in that case.
- `flush`: all `entry_valid` bits cleared at the edge. It has priority over insert, issue and wakeup; the insert is dropped.
- `rst` mid-operation: all state is cleared immediately.

## Timing
- Reset values: `in_ready=1`, `iss_valid=0`, all `iss_*` payload 0, `occupancy=0`, all entries invalid.
- Insert with both operands valid at edge t: `iss_valid` is asserted in cycle t+1.
- CDB capture at edge t: the entry is ready in cycle t+1. There is no same-cycle wakeup-and-issue.
- Issue throughput: 1 per cycle. Insert throughput: 1 per cycle.
- Full boundary: with `occupancy=RS_DEPTH`, `in_ready=0` and `in_valid` is ignored.
- Empty boundary: `iss_valid=0` and `iss_ready` is ignored.
- `iss_valid` may deassert without a handshake only under `flush` or `rst`.

## Configuration
- `RS_AGE_SELECT_EN` defined: oldest-first select.
  - An `RS_DEPTH×RS_DEPTH` age matrix is set on insert: the new entry becomes younger than all valid entries.
  - The ready entry older than all other ready entries is issued.
- `RS_AGE_SELECT_EN` undefined: fixed priority, lowest-index ready entry issues. No age matrix is built.

## Structure
- Shared `data_structures` include carries:
  - typedefs `rs_op`, `rs_entry`, `alu_op_t`;
  - constants `RS_SIZE`, `ROB_IDX_SIZE`, `GPR_SIZE`.
- Parameter defaults derive from these constants.
- One sub-module, `rs_select`: takes the ready vector (plus the age matrix when `RS_AGE_SELECT_EN` is defined) and returns a one-hot grant and `any`.

## Test plan
- Reset, then insert op1={1,-,5} op2={1,-,7} dst=3 -> cycle after: `iss_valid=1`, vals 5/7, `dst_rob=3`. With `iss_ready=1`, `occupancy` returns 0.
- Insert op1 waiting on tag 9; CDB port 1 broadcasts tag 9 value 0x42 two cycles later -> `iss_valid` rises the cycle after the broadcast with `iss_op1_val=0x42`.
- Insert waiting on tag 4 in the same cycle CDB port 0 broadcasts tag 4 value 11 -> the entry captures 11 and issues next cycle.
- Fill 8 entries with `iss_ready=0` -> `in_ready=0`, `occupancy=8`, a 9th insert is ignored. One issue -> `in_ready=1`.
- Insert A (waits on tag 2) then B (ready), broadcast tag 2 -> both ready; `RS_AGE_SELECT_EN` issues A first, otherwise the lower index first.
- With 5 entries valid, assert `flush` together with `in_valid` -> next cycle `occupancy=0`, `iss_valid=0`, insert dropped.
